// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO width converters: counter sizing and LSB-first lane slicing.
package fifo_pkg;

  // Number of bits needed to index `value` distinct items.
  function automatic int clog2_int(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Lane 0 occupies the least significant bits of a packed word.
  function automatic int lane_lsb(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/fifo_width_upsizer_if.sv
// Read side of the upstream FIFO and write side of the downstream FIFO.
// FIFO_WIDTH_UPSIZER_LAST_EN adds the in_last / out_last / out_keep sideband.
interface fifo_width_upsizer_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  // Handshake: a word moves upstream when in_empty_n & in_read, downstream when
  // out_write & out_full_n; out_write/out_din hold steady until that happens.
  logic                 in_empty_n;
  logic                 in_read;
  logic [IN_WIDTH-1:0]  in_dout;
  logic                 out_full_n;
  logic                 out_write;
  logic [OUT_WIDTH-1:0] out_din;
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
  logic                 in_last;
  logic                 out_last;
  logic [RATIO-1:0]     out_keep;

  modport master (
    input  in_empty_n, in_dout, in_last, out_full_n,
    output in_read, out_write, out_din, out_last, out_keep
  );
  modport slave (
    output in_empty_n, in_dout, in_last, out_full_n,
    input  in_read, out_write, out_din, out_last, out_keep
  );
`else
  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_write, out_din
  );
  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_write, out_din
  );
`endif

endinterface

// File: rtl/fifo_width_upsizer_stream_out_reg.sv
// stream_out_reg: single-entry output holding register with a load/accept handshake.
module stream_out_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             full_n,
  output logic             load_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load in the same cycle as an accept keeps valid high for back-to-back words.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && full_n) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign load_ready = ~valid_q | full_n;
  assign valid      = valid_q;
  assign data       = data_q;

endmodule

// File: rtl/fifo_width_upsizer.sv
// Packs RATIO narrow FWFT-FIFO words into one wide word, lane 0 in the LSBs.
// FIFO_WIDTH_UPSIZER_LAST_EN enables early group completion on in_last with out_keep/out_last.
module fifo_width_upsizer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 4,
  parameter int CNT_WIDTH = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  fifo_width_upsizer_if.master bus
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int ACC_WIDTH = IN_WIDTH * (RATIO - 1);
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
  localparam int REG_WIDTH = OUT_WIDTH + 1 + RATIO;
`else
  localparam int REG_WIDTH = OUT_WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  if (RATIO < 2 || CNT_WIDTH < 1 || CNT_WIDTH < clog2_int(RATIO)) begin : g_param_check
    $error("fifo_width_upsizer: RATIO must be >= 2 and CNT_WIDTH wide enough to index RATIO lanes");
  end

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] acc_wide;
  logic [OUT_WIDTH-1:0] packed_word;
  logic                 completing;
  logic                 pop;
  logic                 load;
  logic                 reg_ready;
  logic                 out_valid;
  logic [REG_WIDTH-1:0] reg_in;
  logic [REG_WIDTH-1:0] reg_out;
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
  logic [RATIO-1:0]     keep_mask;
`endif

  always_comb begin
    completing = (count_q == LAST_LANE);
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
    completing = completing | bus.in_last;
    keep_mask  = '0;
`endif
    // Only a completing pop needs the output register; partial lanes have their own storage.
    pop  = bus.in_empty_n & (~completing | reg_ready);
    load = pop & completing;

    acc_wide    = {{IN_WIDTH{1'b0}}, acc_q};
    packed_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(count_q)) begin
        packed_word[lane_lsb(k, IN_WIDTH) +: IN_WIDTH] = acc_wide[lane_lsb(k, IN_WIDTH) +: IN_WIDTH];
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
        keep_mask[k] = 1'b1;
`endif
      end else if (k == int'(count_q)) begin
        packed_word[lane_lsb(k, IN_WIDTH) +: IN_WIDTH] = bus.in_dout;
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
        keep_mask[k] = 1'b1;
`endif
      end
    end

    count_d = count_q;
    if (pop) begin
      if (completing) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
        acc_wide[lane_lsb(int'(count_q), IN_WIDTH) +: IN_WIDTH] = bus.in_dout;
      end
    end
    acc_d = acc_wide[ACC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
  assign reg_in = {keep_mask, bus.in_last, packed_word};
`else
  assign reg_in = packed_word;
`endif

  stream_out_reg #(
    .WIDTH(REG_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (reg_in),
    .full_n    (bus.out_full_n),
    .load_ready(reg_ready),
    .valid     (out_valid),
    .data      (reg_out)
  );

  assign bus.in_read   = pop;
  assign bus.out_write = out_valid;
  assign bus.out_din   = reg_out[OUT_WIDTH-1:0];
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
  assign bus.out_last  = reg_out[OUT_WIDTH];
  assign bus.out_keep  = reg_out[OUT_WIDTH+1 +: RATIO];
`endif

endmodule

// File: tb/tb_fifo_width_upsizer.sv
// Directed bench for fifo_width_upsizer (RATIO=4/IN_WIDTH=32) plus a RATIO=2/IN_WIDTH=8 scoreboard sweep.
// Build with FIFO_WIDTH_UPSIZER_LAST_EN defined to also cover the in_last sideband.
module tb_fifo_width_upsizer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_width_upsizer_if #(.IN_WIDTH(32), .RATIO(4)) bus_a ();
  fifo_width_upsizer #(.IN_WIDTH(32), .RATIO(4), .CNT_WIDTH(2)) dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_a)
  );

  fifo_width_upsizer_if #(.IN_WIDTH(8), .RATIO(2)) bus_b ();
  fifo_width_upsizer #(.IN_WIDTH(8), .RATIO(2), .CNT_WIDTH(1)) dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_a(input logic [31:0] w, input string tag);
    bus_a.in_empty_n = 1'b1;
    bus_a.in_dout    = w;
    #1;
    check(tag, bus_a.in_read, 1'b1);
    step();
  endtask

  task automatic idle_a();
    bus_a.in_empty_n = 1'b0;
    bus_a.in_dout    = 32'hDEAD_BEEF;
    step();
  endtask

  logic        en_pat[7];
  logic [31:0] bub_vals[4];
  int          vi;
  logic [7:0]  words[256];
  int          idx;
  int          cycles;
  int          m_count;
  logic        m_pend;
  logic [7:0]  m_lo;
  logic        e_b;
  logic        f_b;
  logic        exp_read;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    bus_a.in_empty_n = 1'b0;
    bus_a.in_dout    = '0;
    bus_a.out_full_n = 1'b1;
    bus_b.in_empty_n = 1'b0;
    bus_b.in_dout    = '0;
    bus_b.out_full_n = 1'b1;
`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
    bus_a.in_last    = 1'b0;
    bus_b.in_last    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", bus_a.out_write, 1'b0);
    check("rst_din", bus_a.out_din, 128'h0);
    check("rst_read_empty", bus_a.in_read, 1'b0);
    reset_n = 1'b1;
    step();

    // ---- continuous stream ----
    for (int i = 0; i < 8; i++) begin
      pop_a(32'(i), "cont_read");
      if (i == 3) begin
        check("cont_w0_write", bus_a.out_write, 1'b1);
        check("cont_w0_din", bus_a.out_din, 128'h00000003_00000002_00000001_00000000);
      end
      if (i == 4) check("cont_w0_gone", bus_a.out_write, 1'b0);
      if (i == 7) begin
        check("cont_w1_write", bus_a.out_write, 1'b1);
        check("cont_w1_din", bus_a.out_din, 128'h00000007_00000006_00000005_00000004);
      end
    end
    idle_a();
    check("cont_drain", bus_a.out_write, 1'b0);

    // ---- back-pressure ----
    for (int i = 0; i < 4; i++) pop_a(32'h10 + 32'(i), "bp_read_g0");
    check("bp_w0_write", bus_a.out_write, 1'b1);
    bus_a.out_full_n = 1'b0;
    for (int i = 4; i < 7; i++) pop_a(32'h10 + 32'(i), "bp_read_partial");
    check("bp_hold_write", bus_a.out_write, 1'b1);
    check("bp_hold_din", bus_a.out_din, 128'h00000013_00000012_00000011_00000010);
    bus_a.in_empty_n = 1'b1;
    bus_a.in_dout    = 32'h17;
    #1;
    check("bp_stall_read", bus_a.in_read, 1'b0);
    step();
    check("bp_stall_din", bus_a.out_din, 128'h00000013_00000012_00000011_00000010);
    bus_a.out_full_n = 1'b1;
    #1;
    check("bp_release_read", bus_a.in_read, 1'b1);
    step();
    check("bp_w1_write", bus_a.out_write, 1'b1);
    check("bp_w1_din", bus_a.out_din, 128'h00000017_00000016_00000015_00000014);
    idle_a();
    check("bp_drain", bus_a.out_write, 1'b0);

    // ---- bubbly input ----
    en_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bub_vals = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    vi = 0;
    for (int c = 0; c < 7; c++) begin
      bus_a.in_empty_n = en_pat[c];
      if (en_pat[c]) begin
        bus_a.in_dout = bub_vals[vi];
        vi++;
      end else begin
        bus_a.in_dout = 32'hDEAD_BEEF;
      end
      step();
      if (c == 5) check("bub_no_early", bus_a.out_write, 1'b0);
    end
    check("bub_write", bus_a.out_write, 1'b1);
    check("bub_din", bus_a.out_din, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001);
    idle_a();
    check("bub_single", bus_a.out_write, 1'b0);

    // ---- async reset mid-group with a word pending ----
    bus_a.out_full_n = 1'b0;
    for (int i = 0; i < 4; i++) pop_a(32'h30 + 32'(i), "rst_fill");
    check("rst_pending", bus_a.out_write, 1'b1);
    pop_a(32'h34, "rst_partial");
    pop_a(32'h35, "rst_partial");
    bus_a.in_empty_n = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_async_write", bus_a.out_write, 1'b0);
    check("rst_async_din", bus_a.out_din, 128'h0);
    #2;
    reset_n = 1'b1;
    step();
    bus_a.out_full_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop_a(32'h40 + 32'(i), "rst_post_read");
      if (i == 2) check("rst_post_no_early", bus_a.out_write, 1'b0);
    end
    check("rst_post_write", bus_a.out_write, 1'b1);
    check("rst_post_din", bus_a.out_din, 128'h00000043_00000042_00000041_00000040);
    idle_a();

`ifdef FIFO_WIDTH_UPSIZER_LAST_EN
    // ---- early completion on in_last ----
    pop_a(32'hA, "last_read0");
    bus_a.in_last = 1'b1;
    pop_a(32'hB, "last_read1");
    bus_a.in_last = 1'b0;
    check("last_write", bus_a.out_write, 1'b1);
    check("last_din", bus_a.out_din, 128'h00000000_00000000_0000000B_0000000A);
    check("last_keep", bus_a.out_keep, 4'b0011);
    check("last_flag", bus_a.out_last, 1'b1);
    for (int i = 0; i < 4; i++) pop_a(32'h50 + 32'(i), "last_next_read");
    check("last_next_din", bus_a.out_din, 128'h00000053_00000052_00000051_00000050);
    check("last_next_keep", bus_a.out_keep, 4'b1111);
    check("last_next_flag", bus_a.out_last, 1'b0);
    idle_a();
`endif

    // ---- RATIO=2 / IN_WIDTH=8 sweep against a behavioural model ----
    for (int i = 0; i < 256; i++) words[i] = 8'($urandom_range(0, 255));
    idx     = 0;
    cycles  = 0;
    m_count = 0;
    m_pend  = 1'b0;
    m_lo    = '0;
    while ((idx < 256 || m_pend) && cycles < 5000) begin
      e_b = (idx < 256) && ($urandom_range(0, 3) != 0);
      f_b = ($urandom_range(0, 3) != 0);
      bus_b.in_empty_n = e_b;
      bus_b.in_dout    = (idx < 256) ? words[idx] : 8'h00;
      bus_b.out_full_n = f_b;
      #1;
      exp_read = e_b && !(m_count == 1 && m_pend && !f_b);
      check("sw_read", bus_b.in_read, exp_read);
      check("sw_write", bus_b.out_write, m_pend);
      if (m_pend && f_b) begin
        check("sw_din", bus_b.out_din, exp_q.pop_front());
        m_pend = 1'b0;
      end
      if (exp_read) begin
        if (m_count == 1) begin
          exp_q.push_back({words[idx], m_lo});
          m_pend  = 1'b1;
          m_count = 0;
        end else begin
          m_lo    = words[idx];
          m_count = 1;
        end
        idx++;
      end
      step();
      cycles++;
    end
    bus_b.in_empty_n = 1'b0;
    check("sw_all_popped", 32'(idx), 32'd256);
    check("sw_queue_empty", 32'(exp_q.size()), 32'd0);
    step();
    check("sw_idle_write", bus_b.out_write, 1'b0);

    // ---- final report ----
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
